// File: rtl/tile_lookup_arbiter.sv
// Round-robin arbiter that shares the single tilemap read port between Pac-Man and the ghosts.
// Each grant yields one wall bit and a one-cycle acknowledge to the winning requester.
module tile_lookup_arbiter #(
    parameter int NUM_REQ = 5,
    parameter int COLS    = 32,
    parameter int ROWS    = 24,
    parameter int XW      = 5,
    parameter int YW      = 5,
    parameter int AW      = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*XW-1:0] req_x,
    input  logic [NUM_REQ*YW-1:0] req_y,
    output logic [NUM_REQ-1:0]    ack,
    output logic                  wall,
    output logic                  mem_en,
    output logic [AW-1:0]         mem_addr,
    input  logic                  mem_rdata,
    output logic                  busy
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [XW:0] COLS_X = (XW+1)'(COLS);
    localparam logic [YW:0] ROWS_Y = (YW+1)'(ROWS);

    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WAIT, ST_ACK} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               wall_q, wall_d;
    logic               mem_en_q, mem_en_d;
    logic [AW-1:0]      mem_addr_q, mem_addr_d;
    logic               busy_q, busy_d;
    logic [GW-1:0]      grant_q, grant_d;
    logic [GW-1:0]      last_grant_q, last_grant_d;

    logic [GW-1:0]      sel;
    logic               sel_valid;
    logic [XW-1:0]      x_sel;
    logic [YW-1:0]      y_sel;
    logic               in_range;
    logic [AW-1:0]      addr_sel;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        int          cand;
        logic [GW-1:0] cidx;
        sel       = '0;
        sel_valid = 1'b0;
        cand      = 0;
        cidx      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_grant_q) + k) % NUM_REQ;
            cidx = GW'(cand);
            if (!sel_valid && req[cidx]) begin
                sel_valid = 1'b1;
                sel       = cidx;
            end
        end
    end

    assign x_sel    = req_x[sel*XW +: XW];
    assign y_sel    = req_y[sel*YW +: YW];
    assign in_range = ({1'b0, x_sel} < COLS_X) && ({1'b0, y_sel} < ROWS_Y);
    assign addr_sel = AW'(y_sel) * AW'(COLS) + AW'(x_sel);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            ack_q        <= '0;
            wall_q       <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_addr_q   <= '0;
            busy_q       <= 1'b0;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_REQ - 1);
        end else begin
            state_q      <= state_d;
            ack_q        <= ack_d;
            wall_q       <= wall_d;
            mem_en_q     <= mem_en_d;
            mem_addr_q   <= mem_addr_d;
            busy_q       <= busy_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (sel_valid) state_d = in_range ? ST_READ : ST_ACK;
            ST_READ: state_d = ST_WAIT;
            ST_WAIT: state_d = ST_ACK;
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Out-of-range tiles are reported as walls without touching the RAM.
    always_comb begin
        ack_d        = '0;
        wall_d       = wall_q;
        mem_en_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        busy_d       = (state_d != ST_IDLE);
        unique case (state_q)
            ST_IDLE: begin
                if (sel_valid) begin
                    grant_d = sel;
                    if (in_range) begin
                        mem_addr_d = addr_sel;
                        mem_en_d   = 1'b1;
                    end else begin
                        wall_d     = 1'b1;
                        ack_d[sel] = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                wall_d         = mem_rdata;
                ack_d[grant_q] = 1'b1;
            end
            ST_ACK:  last_grant_d = grant_q;
            default: ;
        endcase
    end

    assign ack      = ack_q;
    assign wall     = wall_q;
    assign mem_en   = mem_en_q;
    assign mem_addr = mem_addr_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_tile_lookup_arbiter.sv
// Directed bench for tile_lookup_arbiter: a driver queues expected acks and RAM addresses,
// a negedge monitor pops and compares them whenever the DUT presents mem_en or ack.
module tb_tile_lookup_arbiter;

    localparam int NUM_REQ = 5;
    localparam int XW      = 5;
    localparam int YW      = 5;
    localparam int AW      = 10;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*XW-1:0] req_x;
    logic [NUM_REQ*YW-1:0] req_y;
    logic [NUM_REQ-1:0]    ack;
    logic                  wall;
    logic                  mem_en;
    logic [AW-1:0]         mem_addr;
    logic                  mem_rdata = 1'b0;
    logic                  busy;

    tile_lookup_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_x     (req_x),
        .req_y     (req_y),
        .ack       (ack),
        .wall      (wall),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Tilemap content: wall = addr[0] ^ addr[3]
    logic ram [0:1023];
    always @(posedge clk) if (mem_en) mem_rdata <= ram[mem_addr];

    typedef struct {
        logic [NUM_REQ-1:0] ack;
        logic               wall;
    } exp_t;

    exp_t          exp_q[$];
    logic [AW-1:0] addr_q[$];
    int            checks   = 0;
    int            failures = 0;
    logic          prev_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, want);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (mem_en) begin
            check("mem_en_single_cycle", 32'(prev_en), 0);
            check("mem_en_expected", 32'(addr_q.size() > 0), 1);
            if (addr_q.size() > 0) begin
                check("mem_addr", 32'(mem_addr), 32'(addr_q[0]));
                void'(addr_q.pop_front());
            end
        end
        prev_en <= mem_en;
        if (ack != '0) begin
            $display("txn ack=%b wall=%b", ack, wall);
            check("ack_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                check("ack_vector", 32'(ack), 32'(exp_q[0].ack));
                check("wall", 32'(wall), 32'(exp_q[0].wall));
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic set_req(input int i, input int x, input int y);
        req_x[i*XW +: XW] = XW'(x);
        req_y[i*YW +: YW] = YW'(y);
        req[i]            = 1'b1;
    endtask

    task automatic expect_lookup(input int i, input int addr, input bit uses_mem, input logic w);
        exp_t e;
        if (uses_mem) addr_q.push_back(AW'(addr));
        e.ack  = NUM_REQ'(1 << i);
        e.wall = w;
        exp_q.push_back(e);
    endtask

    task automatic wait_ack(input int idx, output int lat);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack[idx] !== 1'b1 && n < 40);
        check("ack_seen", 32'(ack[idx]), 1);
        lat = n;
    endtask

    int fx[5]    = '{3, 0, 8, 4, 1};
    int fy[5]    = '{2, 0, 1, 10, 0};
    int faddr[5] = '{67, 0, 40, 324, 1};
    logic fwall[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        int lat;
        for (int i = 0; i < 1024; i++) ram[i] = i[0] ^ i[3];
        req   = '0;
        req_x = '0;
        req_y = '0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(ack), 0);
        check("rst_wall", 32'(wall), 0);
        check("rst_mem_en", 32'(mem_en), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_busy", 32'(busy), 0);
        reset = 1'b1;
        @(negedge clk);

        // Single in-range lookup at address 67
        set_req(0, 3, 2);
        expect_lookup(0, 67, 1, 1'b1);
        wait_ack(0, lat);
        check("latency_in_range", 32'(lat), 3);
        check("busy_during_ack", 32'(busy), 1);
        req[0] = 1'b0;
        @(negedge clk);
        check("busy_after_ack", 32'(busy), 0);

        // Out-of-range tiles: wall without a RAM access
        set_req(2, 10, 24);
        expect_lookup(2, 0, 0, 1'b1);
        wait_ack(2, lat);
        check("latency_out_of_range", 32'(lat), 1);
        req[2] = 1'b0;
        @(negedge clk);
        set_req(4, 5, 31);
        expect_lookup(4, 0, 0, 1'b1);
        wait_ack(4, lat);
        check("latency_out_of_range_y31", 32'(lat), 1);
        req[4] = 1'b0;
        @(negedge clk);

        // Fairness: all five held for 20 lookups
        for (int i = 0; i < 5; i++) set_req(i, fx[i], fy[i]);
        for (int k = 0; k < 20; k++) expect_lookup(k % 5, faddr[k % 5], 1, fwall[k % 5]);
        for (int k = 0; k < 20; k++) wait_ack(k % 5, lat);
        req = '0;
        @(negedge clk);

        // Pointer wrap after granting requester 4
        set_req(4, 9, 0);
        set_req(1, 10, 1);
        expect_lookup(1, 42, 1, 1'b1);
        expect_lookup(4, 9, 1, 1'b0);
        wait_ack(1, lat);
        req[1] = 1'b0;
        wait_ack(4, lat);
        req[4] = 1'b0;
        @(negedge clk);

        // Back-to-back: new coordinates presented during the ack cycle
        set_req(0, 3, 2);
        expect_lookup(0, 67, 1, 1'b1);
        expect_lookup(0, 767, 1, 1'b0);
        wait_ack(0, lat);
        set_req(0, 31, 23);
        wait_ack(0, lat);
        req[0] = 1'b0;
        @(negedge clk);

        // Reset while requester 3 is in READ
        set_req(3, 7, 3);
        addr_q.push_back(AW'(103));
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst_ack", 32'(ack), 0);
        check("midrst_mem_en", 32'(mem_en), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_addr_consumed", 32'(addr_q.size()), 0);
        set_req(0, 3, 2);
        expect_lookup(0, 67, 1, 1'b1);
        expect_lookup(3, 103, 1, 1'b1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        wait_ack(0, lat);
        req[0] = 1'b0;
        wait_ack(3, lat);
        req[3] = 1'b0;

        repeat (6) @(negedge clk);
        check("ack_queue_drained", 32'(exp_q.size()), 0);
        check("addr_queue_drained", 32'(addr_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
